// File: rtl/subpel_pass_scheduler.sv
// subpel_pass_scheduler: issue sequencer for the HEVC subpixel interpolation
// datapath. One block is a horizontal pass over every integer row, followed by
// a vertical pass over every column of the integer, A, B and C planes.
// Write-back tags trail the issue slots by PIPE_LAT unstalled cycles.
// Optional build macro: SUBPEL_PERF_CNT_EN enables the busy/stall counters.
module subpel_pass_scheduler #(
  parameter int NUM_PIXEL = 8,
  parameter int TAPS      = 8,
  parameter int PIPE_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic        fir_en,
  output logic        src_valid,
  output logic        src_dir,
  output logic [1:0]  src_plane,
  output logic [7:0]  src_idx,
  output logic        wr_en,
  output logic        wr_dir,
  output logic [1:0]  wr_plane,
  output logic [7:0]  wr_idx,
  output logic [15:0] perf_busy_cycles,
  output logic [15:0] perf_stall_cycles
);

  localparam int ROWS = NUM_PIXEL + TAPS - 1;

  typedef enum logic [2:0] {IDLE, HPASS, VPASS, DRAIN, DONE} state_t;

  typedef struct packed {
    logic       v;
    logic       dir;
    logic [1:0] plane;
    logic [7:0] idx;
  } tag_t;

  state_t     state;
  logic       dir_q;
  logic [1:0] plane_q;
  logic [7:0] idx_q;
  logic [2:0] drain_cnt;
  tag_t       pipe_q [PIPE_LAT];
  tag_t       last_tag;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fir_en    = busy & ~stall;
  assign src_valid = ((state == HPASS) || (state == VPASS)) & ~stall;
  assign src_dir   = dir_q;
  assign src_plane = plane_q;
  assign src_idx   = idx_q;

  assign last_tag  = pipe_q[PIPE_LAT-1];
  assign wr_en     = last_tag.v & ~stall;
  assign wr_dir    = wr_en & last_tag.dir;
  assign wr_plane  = wr_en ? last_tag.plane : '0;
  assign wr_idx    = wr_en ? last_tag.idx : '0;

  // Pass sequencing: the index registers double as the issue-slot tag and are
  // zeroed on leaving VPASS so they read 0 outside the two passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      plane_q   <= '0;
      idx_q     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= HPASS;
            dir_q   <= 1'b0;
            plane_q <= '0;
            idx_q   <= '0;
          end
        end
        HPASS: begin
          if (!stall) begin
            if (idx_q == 8'(ROWS - 1)) begin
              state   <= VPASS;
              dir_q   <= 1'b1;
              plane_q <= '0;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
        end
        VPASS: begin
          if (!stall) begin
            if (idx_q == 8'(NUM_PIXEL - 1)) begin
              idx_q <= '0;
              if (plane_q == 2'd3) begin
                state     <= DRAIN;
                dir_q     <= 1'b0;
                plane_q   <= '0;
                drain_cnt <= '0;
              end else begin
                plane_q <= plane_q + 2'd1;
              end
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (drain_cnt == 3'(PIPE_LAT - 1)) state <= DONE;
            else drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back tag pipeline, frozen together with issue while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
    end else if (!stall) begin
      pipe_q[0] <= '{v: src_valid, dir: dir_q, plane: plane_q, idx: idx_q};
      for (int unsigned i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef SUBPEL_PERF_CNT_EN
  logic [15:0] perf_busy_q;
  logic [15:0] perf_stall_q;

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;

  // Saturating busy/stall counters, restarted whenever a block is accepted.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (busy) begin
      if (perf_busy_q != '1) perf_busy_q <= perf_busy_q + 16'd1;
      if (stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
